// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage occupancy encoding, default PCs, entry width.
package pipe_stage_reg_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

   // instr(32) + pc(32) + a3(5) ahead of the generic payload
   localparam int ENTRY_FIXED_W = 69;

   function automatic int entry_w(input int dw);
      return ENTRY_FIXED_W + dw;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// Load-enabled payload register holding one packed pipeline entry.
// Latency 1 cycle; no flow control of its own, the owner decides when to load.
module pipe_entry_reg #(
   parameter int           W       = 101,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= RST_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer and exception flush.
// Latency 1 cycle; SKID=1 gives a registered in_ready, SKID=0 passes out_ready through.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int          DW       = 32,
   parameter int          SKID     = 1,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
   parameter int          CNTW     = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [31:0]     in_pc,
   input  logic [4:0]      in_a3,
   input  logic [DW-1:0]   in_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [31:0]     out_pc,
   output logic [4:0]      out_a3,
   output logic [DW-1:0]   out_data,
   output logic [CNTW-1:0] flush_cnt
);

   localparam int EW = entry_w(DW);
   localparam logic [EW-1:0] HEAD_RST   = {32'h0, RESET_PC, 5'h0, {DW{1'b0}}};
   localparam logic [EW-1:0] HEAD_FLUSH = {32'h0, EXC_PC, 5'h0, {DW{1'b0}}};

   state_t        state;
   state_t        state_nxt;
   logic [EW-1:0] in_ent;
   logic [EW-1:0] head_q;
   logic [EW-1:0] skid_q;
   logic [EW-1:0] head_d;
   logic          head_ld;
   logic          skid_ld;
   logic          acc;
   logic          con;

   assign in_ent    = {in_instr, in_pc, in_a3, in_data};
   assign out_valid = (state != ST_EMPTY);

   // With the skid slot, readiness depends only on occupancy, so out_ready never reaches in_ready.
   assign in_ready = !flush && ((SKID != 0) ? (state != ST_TWO) : (!out_valid || out_ready));

   assign acc = in_valid && in_ready;
   assign con = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      head_ld   = 1'b0;
      head_d    = in_ent;
      skid_ld   = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
         head_ld   = 1'b1;
         head_d    = HEAD_FLUSH;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (acc) begin
                  state_nxt = ST_ONE;
                  head_ld   = 1'b1;
               end
            end
            ST_ONE: begin
               // Without the skid slot acc implies con here, so ST_TWO is unreachable.
               if (acc && con) begin
                  head_ld = 1'b1;
               end else if (acc) begin
                  state_nxt = ST_TWO;
                  skid_ld   = 1'b1;
               end else if (con) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (con) begin
                  state_nxt = ST_ONE;
                  head_ld   = 1'b1;
                  head_d    = skid_q;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   pipe_entry_reg #(
      .W       (EW),
      .RST_VAL (HEAD_RST)
   ) u_head (
      .clk   (clk),
      .reset (reset),
      .load  (head_ld),
      .d     (head_d),
      .q     (head_q)
   );

   pipe_entry_reg #(
      .W       (EW),
      .RST_VAL ('0)
   ) u_skid (
      .clk   (clk),
      .reset (reset),
      .load  (skid_ld),
      .d     (in_ent),
      .q     (skid_q)
   );

   assign {out_instr, out_pc, out_a3, out_data} = head_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         flush_cnt <= '0;
      end else if (flush && (flush_cnt != {CNTW{1'b1}})) begin
         flush_cnt <= flush_cnt + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: dut_a is the skid-buffer build, dut_b the single-register build with a 4-bit flush counter.
module tb_pipe_stage_reg;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   logic        in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a;
   logic [31:0] in_instr_a, in_pc_a, in_data_a, out_instr_a, out_pc_a, out_data_a;
   logic [4:0]  in_a3_a, out_a3_a;
   logic [15:0] flush_cnt_a;

   logic        in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b;
   logic [31:0] in_instr_b, in_pc_b, in_data_b, out_instr_b, out_pc_b, out_data_b;
   logic [4:0]  in_a3_b, out_a3_b;
   logic [3:0]  flush_cnt_b;

   logic [31:0] exp_a[$];
   logic [31:0] exp_b[$];
   logic [31:0] pop_a;
   logic [31:0] pop_b;

   pipe_stage_reg #(.DW(32), .SKID(1), .CNTW(16)) dut_a (
      .clk(clk), .reset(reset),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_instr(in_instr_a),
      .in_pc(in_pc_a), .in_a3(in_a3_a), .in_data(in_data_a), .flush(flush_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_instr(out_instr_a),
      .out_pc(out_pc_a), .out_a3(out_a3_a), .out_data(out_data_a),
      .flush_cnt(flush_cnt_a)
   );

   pipe_stage_reg #(.DW(32), .SKID(0), .CNTW(4)) dut_b (
      .clk(clk), .reset(reset),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_instr(in_instr_b),
      .in_pc(in_pc_b), .in_a3(in_a3_b), .in_data(in_data_b), .flush(flush_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_instr(out_instr_b),
      .out_pc(out_pc_b), .out_a3(out_a3_b), .out_data(out_data_b),
      .flush_cnt(flush_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Payload fields are derived from the pc so one pushed pc fixes the whole expected entry.
   function automatic logic [100:0] mk(input logic [31:0] pc);
      return {pc ^ 32'hA5A5_0000, pc, pc[6:2], ~pc};
   endfunction

   task automatic offer_a(input logic [31:0] pc);
      in_pc_a    = pc;
      in_instr_a = pc ^ 32'hA5A5_0000;
      in_a3_a    = pc[6:2];
      in_data_a  = ~pc;
   endtask

   task automatic offer_b(input logic [31:0] pc);
      in_pc_b    = pc;
      in_instr_b = pc ^ 32'hA5A5_0000;
      in_a3_b    = pc[6:2];
      in_data_b  = ~pc;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (reset && out_valid_a && out_ready_a) begin
         checks++;
         if (exp_a.size() == 0) begin
            errors++;
            $display("FAIL mon_a_unexpected got_pc=%h want=none", out_pc_a);
         end else begin
            pop_a = exp_a.pop_front();
            if ({out_instr_a, out_pc_a, out_a3_a, out_data_a} !== mk(pop_a)) begin
               errors++;
               $display("FAIL mon_a_entry got_pc=%h want_pc=%h", out_pc_a, pop_a);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset && out_valid_b && out_ready_b) begin
         checks++;
         if (exp_b.size() == 0) begin
            errors++;
            $display("FAIL mon_b_unexpected got_pc=%h want=none", out_pc_b);
         end else begin
            pop_b = exp_b.pop_front();
            if ({out_instr_b, out_pc_b, out_a3_b, out_data_b} !== mk(pop_b)) begin
               errors++;
               $display("FAIL mon_b_entry got_pc=%h want_pc=%h", out_pc_b, pop_b);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      in_valid_a = 1'b0; out_ready_a = 1'b0; flush_a = 1'b0; offer_a(32'h0);
      in_valid_b = 1'b0; out_ready_b = 1'b0; flush_b = 1'b0; offer_b(32'h0);

      // Reset for two cycles
      step();
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_a_valid", 32'(out_valid_a), 32'd0);
      chk("rst_a_pc", out_pc_a, 32'h0000_3000);
      chk("rst_a_cnt", 32'(flush_cnt_a), 32'd0);
      chk("rst_a_ready", 32'(in_ready_a), 32'd1);
      chk("rst_b_valid", 32'(out_valid_b), 32'd0);
      chk("rst_b_pc", out_pc_b, 32'h0000_3000);
      chk("rst_b_cnt", 32'(flush_cnt_b), 32'd0);
      chk("rst_b_ready", 32'(in_ready_b), 32'd1);

      // Skid backpressure: fill to TWO, then drain in order
      step();
      in_valid_a = 1'b1; offer_a(32'h3000); exp_a.push_back(32'h3000);
      step();
      offer_a(32'h3004); exp_a.push_back(32'h3004);
      step();
      in_valid_a = 1'b0;
      @(negedge clk);
      chk("two_ready", 32'(in_ready_a), 32'd0);
      chk("two_valid", 32'(out_valid_a), 32'd1);
      chk("two_head", out_pc_a, 32'h3000);
      step();
      out_ready_a = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("drain_empty", 32'(exp_a.size()), 32'd0);
      chk("drain_valid", 32'(out_valid_a), 32'd0);
      chk("drain_hold_pc", out_pc_a, 32'h3004);

      // Flush in TWO with a new entry offered at the same time
      step();
      out_ready_a = 1'b0;
      in_valid_a = 1'b1; offer_a(32'h3100);
      step();
      offer_a(32'h3104);
      step();
      offer_a(32'h3008);
      flush_a = 1'b1;
      @(negedge clk);
      chk("flush_ready", 32'(in_ready_a), 32'd0);
      step();
      flush_a = 1'b0;
      in_valid_a = 1'b0;
      @(negedge clk);
      chk("flush_valid", 32'(out_valid_a), 32'd0);
      chk("flush_pc", out_pc_a, 32'h0000_4180);
      chk("flush_instr", out_instr_a, 32'h0);
      chk("flush_a3", 32'(out_a3_a), 32'h0);
      chk("flush_data", out_data_a, 32'h0);
      chk("flush_cnt", 32'(flush_cnt_a), 32'd1);
      step();
      out_ready_a = 1'b1;
      step();
      step();
      step();
      @(negedge clk);
      chk("flush_pc_hold", out_pc_a, 32'h0000_4180);

      // Single-register streaming: one output per cycle, no bubbles
      out_ready_b = 1'b1;
      in_valid_b = 1'b1;
      for (int k = 0; k < 8; k++) begin
         offer_b(32'h3000 + 32'(4 * k));
         exp_b.push_back(32'h3000 + 32'(4 * k));
         if (k > 0) begin
            @(negedge clk);
            chk("stream_valid", 32'(out_valid_b), 32'd1);
         end
         step();
      end

      // Single-register backpressure then simultaneous consume/accept
      offer_b(32'h3040); exp_b.push_back(32'h3040);
      step();
      out_ready_b = 1'b0;
      offer_b(32'h3044); exp_b.push_back(32'h3044);
      @(negedge clk);
      chk("reg_bp_ready", 32'(in_ready_b), 32'd0);
      step();
      out_ready_b = 1'b1;
      step();
      in_valid_b = 1'b0;
      step();
      @(negedge clk);
      chk("reg_empty", 32'(exp_b.size()), 32'd0);
      chk("reg_valid", 32'(out_valid_b), 32'd0);

      // Counter saturation on the 4-bit build, with an offer that must be refused
      step();
      flush_b = 1'b1;
      in_valid_b = 1'b1; offer_b(32'h3ff0);
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 14) begin
            @(negedge clk);
            chk("sat_cnt14", 32'(flush_cnt_b), 32'hE);
            chk("sat_ready", 32'(in_ready_b), 32'd0);
         end
      end
      flush_b = 1'b0;
      in_valid_b = 1'b0;
      @(negedge clk);
      chk("sat_cnt", 32'(flush_cnt_b), 32'hF);
      chk("sat_valid", 32'(out_valid_b), 32'd0);

      // Reset wins over flush and handshake
      step();
      reset = 1'b0;
      flush_a = 1'b1;
      flush_b = 1'b1;
      in_valid_a = 1'b1; offer_a(32'h3200);
      step();
      reset = 1'b1;
      flush_a = 1'b0;
      flush_b = 1'b0;
      in_valid_a = 1'b0;
      @(negedge clk);
      chk("rw_a_pc", out_pc_a, 32'h0000_3000);
      chk("rw_a_cnt", 32'(flush_cnt_a), 32'd0);
      chk("rw_a_valid", 32'(out_valid_a), 32'd0);
      chk("rw_b_cnt", 32'(flush_cnt_b), 32'd0);
      chk("rw_b_pc", out_pc_b, 32'h0000_3000);

      step();
      step();
      @(negedge clk);
      chk("end_a_queue", 32'(exp_a.size()), 32'd0);
      chk("end_b_queue", 32'(exp_b.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
